// File: rtl/pc_update_ctrl.sv
// pc_update_ctrl: sequences PC-source select and PC/EPC write enables of the
// multicycle datapath for each instruction accepted from the decoder.
//
// Handshake: an instruction transfers on a clock edge where op_valid and
// op_ready are both high; op_ready is high only while the FSM is in IDLE, and
// op_class is captured on that edge. done pulses for one cycle at the end.
//
// Optional feature: define PC_RETIRE_CNT_EN to build the retired-PC-update
// counter on retire_count; otherwise retire_count is a constant zero.
//
// All outputs are registers decoded from the next state, so they are Moore
// functions of the registered state. state_dbg exposes the FSM state.

module pc_update_ctrl #(
   parameter int unsigned BRANCH_LAT = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [2:0]  op_class,
   input  logic        alu_zero,
   input  logic        exc_req,
   output logic [3:0]  pc_source,
   output logic        pc_write,
   output logic        epc_write,
   output logic        done,
   output logic [31:0] retire_count,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_EVAL   = 3'd2,
      S_COMMIT = 3'd3,
      S_TRAP   = 3'd4,
      S_DONE   = 3'd5
   } state_e;

   localparam logic [2:0] C_SEQ  = 3'd0;
   localparam logic [2:0] C_BEQ  = 3'd1;
   localparam logic [2:0] C_BNE  = 3'd2;
   localparam logic [2:0] C_JUMP = 3'd3;

   localparam logic [3:0] SRC_SEQ    = 4'b0000;
   localparam logic [3:0] SRC_TRAP   = 4'b0001;
   localparam logic [3:0] SRC_BRANCH = 4'b0010;
   localparam logic [3:0] SRC_JUMP   = 4'b0011;

   // EVAL lasts BRANCH_LAT cycles: counter runs BRANCH_LAT-1 down to 0.
   localparam logic [3:0] LAT_M1 = 4'(BRANCH_LAT - 1);

   state_e      state_q, state_d;
   logic [2:0]  class_q, class_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        exc_q, exc_d;
   logic        exc_now;
   logic        taken;
   logic [3:0]  src_d;

   logic        op_ready_q;
   logic        pc_write_q;
   logic        epc_write_q;
   logic        done_q;
   logic [3:0]  pc_source_q;

   // Next-state logic; a same-cycle exc_req counts as pending in FETCH/EVAL/COMMIT.
   always_comb begin
      state_d = state_q;
      class_d = class_q;
      cnt_d   = cnt_q;
      exc_d   = exc_q;
      exc_now = exc_q | (exc_req & ((state_q == S_FETCH) ||
                                    (state_q == S_EVAL)  ||
                                    (state_q == S_COMMIT)));
      taken   = ((class_q == C_BEQ) &&  alu_zero) ||
                ((class_q == C_BNE) && !alu_zero) ||
                 (class_q == C_JUMP);
      case (state_q)
         S_IDLE: begin
            if (op_valid) begin
               class_d = op_class;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            exc_d = exc_now;
            if (exc_now || class_q[2]) begin
               state_d = S_TRAP;
            end else if (class_q == C_SEQ) begin
               state_d = S_DONE;
            end else begin
               state_d = S_EVAL;
               cnt_d   = LAT_M1;
            end
         end
         S_EVAL: begin
            exc_d = exc_now;
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (exc_now) begin
               state_d = S_TRAP;
            end else if (taken) begin
               state_d = S_COMMIT;
            end else begin
               state_d = S_DONE;
            end
         end
         S_COMMIT: begin
            exc_d   = exc_now;
            state_d = exc_now ? S_TRAP : S_DONE;
         end
         S_TRAP: begin
            exc_d   = 1'b0;
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      case (state_d)
         S_COMMIT: src_d = (class_d == C_JUMP) ? SRC_JUMP : SRC_BRANCH;
         S_TRAP:   src_d = SRC_TRAP;
         default:  src_d = SRC_SEQ;
      endcase
   end

   // FSM state plus outputs registered from the next state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         class_q     <= 3'd0;
         cnt_q       <= 4'd0;
         exc_q       <= 1'b0;
         op_ready_q  <= 1'b1;
         pc_write_q  <= 1'b0;
         epc_write_q <= 1'b0;
         done_q      <= 1'b0;
         pc_source_q <= SRC_SEQ;
      end else begin
         state_q     <= state_d;
         class_q     <= class_d;
         cnt_q       <= cnt_d;
         exc_q       <= exc_d;
         op_ready_q  <= (state_d == S_IDLE);
         pc_write_q  <= (state_d == S_FETCH) || (state_d == S_COMMIT) ||
                        (state_d == S_TRAP);
         epc_write_q <= (state_d == S_TRAP);
         done_q      <= (state_d == S_DONE);
         pc_source_q <= src_d;
      end
   end

   assign op_ready  = op_ready_q;
   assign pc_write  = pc_write_q;
   assign epc_write = epc_write_q;
   assign done      = done_q;
   assign pc_source = pc_source_q;
   assign state_dbg = state_q;

`ifdef PC_RETIRE_CNT_EN
   logic [31:0] retire_q;

   // Count every cycle the PC register is loaded; wraps naturally.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         retire_q <= 32'd0;
      end else if (pc_write_q) begin
         retire_q <= retire_q + 32'd1;
      end
   end

   assign retire_count = retire_q;
`else
   assign retire_count = 32'd0;
`endif

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Testbench for pc_update_ctrl (BRANCH_LAT = 2). Expected per-cycle output
// vectors are pushed to exp_q from the latency table; run_op records the
// observed vectors, and each test task pops and compares them.
// Vector layout: {retire_count[31:0], op_ready, pc_write, epc_write, done, pc_source[3:0]}.

module tb_pc_update_ctrl;

   localparam int L         = 2;
   localparam int LAST_EVAL = 1 + L;  // cycle offset of the final EVAL cycle

`ifdef PC_RETIRE_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   localparam logic [7:0] V_IDLE  = 8'h80;
   localparam logic [7:0] V_FETCH = 8'h40;
   localparam logic [7:0] V_EVAL  = 8'h00;
   localparam logic [7:0] V_CMT_B = 8'h42;
   localparam logic [7:0] V_CMT_J = 8'h43;
   localparam logic [7:0] V_TRAP  = 8'h61;
   localparam logic [7:0] V_DONE  = 8'h10;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        op_valid;
   logic        op_ready;
   logic [2:0]  op_class;
   logic        alu_zero;
   logic        exc_req;
   logic [3:0]  pc_source;
   logic        pc_write;
   logic        epc_write;
   logic        done;
   logic [31:0] retire_count;
   logic [2:0]  state_dbg;

   int checks = 0;
   int errors = 0;
   logic [39:0] exp_q[$];
   logic [39:0] obs_q[$];
   logic [31:0] exp_ret = 32'd0;

   pc_update_ctrl #(.BRANCH_LAT(L)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .op_valid     (op_valid),
      .op_ready     (op_ready),
      .op_class     (op_class),
      .alu_zero     (alu_zero),
      .exc_req      (exc_req),
      .pc_source    (pc_source),
      .pc_write     (pc_write),
      .epc_write    (epc_write),
      .done         (done),
      .retire_count (retire_count),
      .state_dbg    (state_dbg)
   );

   // ---------------- clock / reset / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1);
   end

   // ---------------- scoreboard helpers ----------------
   function automatic void push_exp(input logic [7:0] v);
      exp_q.push_back({exp_ret, v});
      if (CNT_EN && v[6]) exp_ret = exp_ret + 32'd1;
   endfunction

   function automatic logic [7:0] out_vec();
      return {op_ready, pc_write, epc_write, done, pc_source};
   endfunction

   // ---------------- driver ----------------
   // Offers one instruction at cycle 0 and records cycles 0..n. exc_req pulses
   // at cycle exc_k (negative: never). alu_zero carries alu_last only on the
   // final EVAL cycle and its complement on every other cycle.
   task automatic run_op(input logic [2:0] cls, input int n, input int exc_k,
                         input logic alu_last, input bit hold);
      for (int k = 0; k <= n; k++) begin
         @(posedge clk);
         #1;
         op_valid = hold || (k == 0);
         op_class = cls;
         exc_req  = (k == exc_k);
         alu_zero = (k == LAST_EVAL) ? alu_last : ~alu_last;
         @(negedge clk);
         obs_q.push_back({retire_count, out_vec()});
      end
      op_valid = 1'b0;
      exc_req  = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [7:0] v;
      reset_n  = 1'b0;
      op_valid = 1'b0;
      op_class = 3'd0;
      alu_zero = 1'b0;
      exc_req  = 1'b0;
      repeat (2) @(negedge clk);
      v = out_vec();
      checks++;
      if (v !== V_IDLE || retire_count !== 32'd0 || state_dbg !== 3'd0) begin
         errors++;
         $display("FAIL reset_values: got vec=%h retire=%h state=%0d, expected vec=%h retire=0 state=0",
                  v, retire_count, state_dbg, V_IDLE);
      end
      reset_n = 1'b1;
      exp_ret = 32'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         v = out_vec();
         checks++;
         if (v !== V_IDLE || retire_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_idle_hold: cycle %0d got vec=%h retire=%h, expected vec=%h retire=0",
                     i, v, retire_count, V_IDLE);
         end
      end
      // Start a BEQ and pull reset while in EVAL.
      push_exp(V_IDLE); push_exp(V_FETCH); push_exp(V_EVAL);
      run_op(3'd1, 2, -1, 1'b1, 1'b0);
      while (exp_q.size() != 0) begin
         logic [39:0] e, o;
         e = exp_q.pop_front();
         o = 'x;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reset_pre_eval: got vec=%h retire=%h, expected vec=%h retire=%h",
                     o[7:0], o[39:8], e[7:0], e[39:8]);
         end
      end
      obs_q.delete();
      @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      v = out_vec();
      checks++;
      if (v !== V_IDLE) begin
         errors++;
         $display("FAIL reset_async_mid_eval: got vec=%h, expected vec=%h", v, V_IDLE);
      end
      @(negedge clk);
      v = out_vec();
      checks++;
      if (v !== V_IDLE || retire_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_held_mid_eval: got vec=%h retire=%h, expected vec=%h retire=0",
                  v, retire_count, V_IDLE);
      end
      reset_n = 1'b1;
      exp_ret = 32'd0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         v = out_vec();
         checks++;
         if (v !== V_IDLE || retire_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_after_release: cycle %0d got vec=%h retire=%h, expected vec=%h retire=0",
                     i, v, retire_count, V_IDLE);
         end
      end
   endtask

   task automatic test_seq();
      // Plain SEQ, then SEQ with exc_req on the IDLE accept cycle (ignored).
      for (int r = 0; r < 2; r++) begin
         push_exp(V_IDLE); push_exp(V_FETCH); push_exp(V_DONE); push_exp(V_IDLE);
         run_op(3'd0, 3, (r == 0) ? -1 : 0, 1'($urandom_range(0, 1)), 1'b0);
      end
      while (exp_q.size() != 0) begin
         logic [39:0] e, o;
         e = exp_q.pop_front();
         o = 'x;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL seq: got vec=%h retire=%h, expected vec=%h retire=%h",
                     o[7:0], o[39:8], e[7:0], e[39:8]);
         end
      end
      obs_q.delete();
   endtask

   task automatic test_branch();
      logic [2:0] cls_tab [4] = '{3'd1, 3'd1, 3'd2, 3'd2};
      logic       alu_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      bit         tkn_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         push_exp(V_IDLE); push_exp(V_FETCH); push_exp(V_EVAL); push_exp(V_EVAL);
         if (tkn_tab[i]) push_exp(V_CMT_B);
         push_exp(V_DONE); push_exp(V_IDLE);
         run_op(cls_tab[i], tkn_tab[i] ? 6 : 5, -1, alu_tab[i], 1'b0);
      end
      while (exp_q.size() != 0) begin
         logic [39:0] e, o;
         e = exp_q.pop_front();
         o = 'x;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL branch: got vec=%h retire=%h, expected vec=%h retire=%h",
                     o[7:0], o[39:8], e[7:0], e[39:8]);
         end
      end
      obs_q.delete();
   endtask

   task automatic test_jump();
      for (int i = 0; i < 2; i++) begin
         push_exp(V_IDLE); push_exp(V_FETCH); push_exp(V_EVAL); push_exp(V_EVAL);
         push_exp(V_CMT_J); push_exp(V_DONE); push_exp(V_IDLE);
         run_op(3'd3, 6, -1, 1'(i), 1'b0);
      end
      while (exp_q.size() != 0) begin
         logic [39:0] e, o;
         e = exp_q.pop_front();
         o = 'x;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL jump: got vec=%h retire=%h, expected vec=%h retire=%h",
                     o[7:0], o[39:8], e[7:0], e[39:8]);
         end
      end
      obs_q.delete();
   endtask

   task automatic test_exceptions();
      // exc_req during FETCH of SEQ
      push_exp(V_IDLE); push_exp(V_FETCH); push_exp(V_TRAP); push_exp(V_DONE); push_exp(V_IDLE);
      run_op(3'd0, 4, 1, 1'b0, 1'b0);
      // illegal classes 5 and 7
      push_exp(V_IDLE); push_exp(V_FETCH); push_exp(V_TRAP); push_exp(V_DONE); push_exp(V_IDLE);
      run_op(3'd5, 4, -1, 1'b0, 1'b0);
      push_exp(V_IDLE); push_exp(V_FETCH); push_exp(V_TRAP); push_exp(V_DONE); push_exp(V_IDLE);
      run_op(3'd7, 4, -1, 1'b1, 1'b0);
      // exc_req during COMMIT of JUMP: redirect write, then vector write
      push_exp(V_IDLE); push_exp(V_FETCH); push_exp(V_EVAL); push_exp(V_EVAL);
      push_exp(V_CMT_J); push_exp(V_TRAP); push_exp(V_DONE); push_exp(V_IDLE);
      run_op(3'd3, 7, 4, 1'b0, 1'b0);
      // exc_req on first EVAL cycle of a would-be-taken BEQ: sticky, traps at decision
      push_exp(V_IDLE); push_exp(V_FETCH); push_exp(V_EVAL); push_exp(V_EVAL);
      push_exp(V_TRAP); push_exp(V_DONE); push_exp(V_IDLE);
      run_op(3'd1, 6, 2, 1'b1, 1'b0);
      while (exp_q.size() != 0) begin
         logic [39:0] e, o;
         e = exp_q.pop_front();
         o = 'x;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL exception: got vec=%h retire=%h, expected vec=%h retire=%h",
                     o[7:0], o[39:8], e[7:0], e[39:8]);
         end
      end
      obs_q.delete();
   endtask

   task automatic test_back_to_back();
      // op_valid held high: second SEQ accepted on the IDLE cycle after DONE.
      push_exp(V_IDLE); push_exp(V_FETCH); push_exp(V_DONE);
      push_exp(V_IDLE); push_exp(V_FETCH); push_exp(V_DONE);
      run_op(3'd0, 5, -1, 1'b0, 1'b1);
      while (exp_q.size() != 0) begin
         logic [39:0] e, o;
         e = exp_q.pop_front();
         o = 'x;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL back_to_back: got vec=%h retire=%h, expected vec=%h retire=%h",
                     o[7:0], o[39:8], e[7:0], e[39:8]);
         end
      end
      obs_q.delete();
   endtask

   task automatic test_counter();
      logic [31:0] want;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      exp_ret = 32'd0;
      // SEQ (1 write) + taken BEQ (2 writes) + trapped SEQ (2 writes)
      push_exp(V_IDLE); push_exp(V_FETCH); push_exp(V_DONE); push_exp(V_IDLE);
      run_op(3'd0, 3, -1, 1'b0, 1'b0);
      push_exp(V_IDLE); push_exp(V_FETCH); push_exp(V_EVAL); push_exp(V_EVAL);
      push_exp(V_CMT_B); push_exp(V_DONE); push_exp(V_IDLE);
      run_op(3'd1, 6, -1, 1'b1, 1'b0);
      push_exp(V_IDLE); push_exp(V_FETCH); push_exp(V_TRAP); push_exp(V_DONE); push_exp(V_IDLE);
      run_op(3'd0, 4, 1, 1'b0, 1'b0);
      while (exp_q.size() != 0) begin
         logic [39:0] e, o;
         e = exp_q.pop_front();
         o = 'x;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL counter_seq: got vec=%h retire=%h, expected vec=%h retire=%h",
                     o[7:0], o[39:8], e[7:0], e[39:8]);
         end
      end
      obs_q.delete();
      want = CNT_EN ? 32'd5 : 32'd0;
      checks++;
      if (retire_count !== want) begin
         errors++;
         $display("FAIL counter_total: got retire=%0d, expected %0d", retire_count, want);
      end
`ifdef PC_RETIRE_CNT_EN
      // Preload near the top and let a taken branch wrap it.
      @(negedge clk);
      force dut.retire_q = 32'hFFFF_FFFE;
      @(posedge clk);
      #1 release dut.retire_q;
      exp_ret = 32'hFFFF_FFFE;
      push_exp(V_IDLE); push_exp(V_FETCH); push_exp(V_EVAL); push_exp(V_EVAL);
      push_exp(V_CMT_B); push_exp(V_DONE); push_exp(V_IDLE);
      run_op(3'd2, 6, -1, 1'b0, 1'b0);
      while (exp_q.size() != 0) begin
         logic [39:0] e, o;
         e = exp_q.pop_front();
         o = 'x;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL counter_wrap_seq: got vec=%h retire=%h, expected vec=%h retire=%h",
                     o[7:0], o[39:8], e[7:0], e[39:8]);
         end
      end
      obs_q.delete();
      checks++;
      if (retire_count !== 32'd0) begin
         errors++;
         $display("FAIL counter_wrap: got retire=%h, expected 00000000", retire_count);
      end
`endif
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_seq();
      test_branch();
      test_jump();
      test_exceptions();
      test_back_to_back();
      test_counter();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
